// File: rtl/player_draw_if.sv
// vga_if: VGA timing/pixel bundle passed between pipeline stages.
// The "in" modport consumes a stream, the "out" modport produces one.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/player_draw.sv
// player_draw: overlays a 32x32 animated player sprite on the VGA stream.
// Position and facing are latched once per frame at the vblnk rising edge,
// the sprite ROM (1-cycle synchronous read) is addressed one stage after the
// window test, and every output field leaves with a fixed 3-cycle latency.
// Optional feature macro: PLAYER_MIRROR_EN (horizontal flip when facing left).
module player_draw #(
  parameter int          ANIM_FRAMES = 8,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_game,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        moving,
  input  logic        facing_left,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] pixel_addr,
  vga_if.in           in,
  vga_if.out          out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  localparam logic [0:0] FRAME_A = 1'b0;
  localparam logic [0:0] FRAME_B = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(ANIM_FRAMES - 1);

  logic        vblnk_prev;
  logic        fs;
  logic [10:0] x_lat, y_lat;
  logic [0:0]  anim_frame;
  logic [7:0]  cnt;
  logic        hit, hit_d1, hit_d2;
  logic [11:0] x_end, y_end;
  logic [4:0]  col, row, col_sel;
  vga_t        cur, px_d1, px_d2, o_q;

  assign fs = in.vblnk & ~vblnk_prev;

  // Frame-start detection, per-frame position latch and walk animation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
      anim_frame <= FRAME_A;
      cnt        <= '0;
    end else begin
      vblnk_prev <= in.vblnk;
      if (fs) begin
        x_lat <= xpos;
        y_lat <= ypos;
        if (!moving) begin
          cnt        <= '0;
          anim_frame <= FRAME_A;
        end else if (cnt == CNT_LAST) begin
          cnt        <= '0;
          anim_frame <= (anim_frame == FRAME_A) ? FRAME_B : FRAME_A;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

`ifdef PLAYER_MIRROR_EN
  logic left_lat;

  // Facing direction is latched with the position so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  left_lat <= 1'b0;
    else if (fs) left_lat <= facing_left;
  end

  assign col_sel = left_lat ? (5'd31 - col) : col;
`else
  logic unused_facing;
  assign unused_facing = facing_left;
  assign col_sel       = col;
`endif

  // Window bounds are formed at 12 bits so a player near column/row 2047
  // clips at the screen edge instead of wrapping back to 0.
  assign x_end = {1'b0, x_lat} + 12'd32;
  assign y_end = {1'b0, y_lat} + 12'd32;
  assign hit   = start_game & ~in.hblnk & ~in.vblnk
               & (in.hcount >= x_lat) & ({1'b0, in.hcount} < x_end)
               & (in.vcount >= y_lat) & ({1'b0, in.vcount} < y_end);

  // Only the low 5 bits of the offset matter inside the window.
  assign col = in.hcount[4:0] - x_lat[4:0];
  assign row = in.vcount[4:0] - y_lat[4:0];

  assign cur = {in.hcount, in.vcount, in.hsync, in.hblnk, in.vsync, in.vblnk, in.rgb};

  // Stage 1: ROM address (held outside the window) and timing delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      hit_d1     <= 1'b0;
      px_d1      <= '0;
    end else begin
      if (hit) pixel_addr <= {anim_frame, row, col_sel};
      hit_d1 <= hit;
      px_d1  <= cur;
    end
  end

  // Stage 2: wait for the ROM read to land on rgb_pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_d2 <= 1'b0;
      px_d2  <= '0;
    end else begin
      hit_d2 <= hit_d1;
      px_d2  <= px_d1;
    end
  end

  // Stage 3: merge sprite over background, key colour shows background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
    end else begin
      o_q <= px_d2;
      if (hit_d2 && (rgb_pixel != KEY_COLOR)) o_q.rgb <= rgb_pixel;
    end
  end

  assign out.hcount = o_q.hcount;
  assign out.vcount = o_q.vcount;
  assign out.hsync  = o_q.hsync;
  assign out.hblnk  = o_q.hblnk;
  assign out.vsync  = o_q.vsync;
  assign out.vblnk  = o_q.vblnk;
  assign out.rgb    = o_q.rgb;

endmodule

// File: tb/tb_player_draw.sv
// tb_player_draw: table vectors, directed multi-cycle sequences and a
// randomized run, all checked against a frame-level reference model.
module tb_player_draw;
  localparam int          AF  = 8;
  localparam logic [11:0] KEY = 12'hF0F;
`ifdef PLAYER_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct {
    int          h;
    int          v;
    bit          hb;
    logic [11:0] rgb;
    logic [10:0] addr;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_game = 1'b0, moving = 1'b0, facing_left = 1'b0;
  logic [10:0] xpos = '0, ypos = '0;
  logic [11:0] rgb_pixel;
  logic [10:0] pixel_addr;

  vga_if vin ();
  vga_if vout ();

  player_draw #(.ANIM_FRAMES(AF), .KEY_COLOR(KEY)) dut (
    .clk(clk), .rst_n(rst_n), .start_game(start_game), .xpos(xpos), .ypos(ypos),
    .moving(moving), .facing_left(facing_left), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr), .in(vin), .out(vout)
  );

  always #5 clk = ~clk;

  int rom_mode = 0;
  int tests = 0, fails = 0;

  function automatic logic [11:0] rom_f(int mode, logic [10:0] a);
    case (mode)
      0:       return 12'h0F0;
      1:       return KEY;
      default: return (a[3:0] == 4'h5) ? KEY : {1'b0, a};
    endcase
  endfunction

  // Sprite ROM with one cycle of read latency
  always @(posedge clk) rgb_pixel <= rom_f(rom_mode, pixel_addr);

  // reference model state
  int          mx, my, mk;
  bit          mleft, prev_vb;
  logic [10:0] m_addr;
  vga_t        exp_q[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vga_t get_out();
    return {vout.hcount, vout.vcount, vout.hsync, vout.hblnk, vout.vsync, vout.vblnk, vout.rgb};
  endfunction

  task automatic reset_model();
    mx = 0; my = 0; mk = 0; mleft = 0; prev_vb = 0; m_addr = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic drive(int h, int v, bit hb, bit vb, logic [11:0] rgb);
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.hblnk  = hb;     vin.vblnk  = vb;
    vin.hsync  = 1'($urandom); vin.vsync = 1'($urandom);
    vin.rgb    = rgb;
  endtask

  // One pixel clock: predict, advance, compare address and 2-cycle-old output.
  task automatic step();
    vga_t e;
    bit hit;
    int h, v, col, row, ce;
    logic [10:0] a;
    logic [11:0] rd;
    h = int'(vin.hcount); v = int'(vin.vcount);
    hit = start_game && !vin.hblnk && !vin.vblnk &&
          h >= mx && h < mx + 32 && v >= my && v < my + 32;
    e = {vin.hcount, vin.vcount, vin.hsync, vin.hblnk, vin.vsync, vin.vblnk, vin.rgb};
    if (hit) begin
      col = h - mx; row = v - my;
      ce  = (MIRROR && mleft) ? 31 - col : col;
      a   = 11'(((mk / AF) % 2) * 1024 + row * 32 + ce);
      m_addr = a;
      rd = rom_f(rom_mode, a);
      if (rd != KEY) e.rgb = rd;
    end
    exp_q.push_back(e);
    if (vin.vblnk && !prev_vb) begin
      mx = int'(xpos); my = int'(ypos); mleft = facing_left;
      mk = moving ? mk + 1 : 0;
    end
    prev_vb = vin.vblnk;
    @(posedge clk); #1;
    chk("pixel_addr", 64'(pixel_addr), 64'(m_addr));
    chk("out", 64'(get_out()), 64'(exp_q.pop_front()));
  endtask

  task automatic fs_pulse();
    drive(0, 0, 1, 0, 12'h0); step();
    vin.vblnk = 1'b1;         step();
    vin.vblnk = 1'b0;         step();
  endtask

  task automatic idle3();
    drive(0, 0, 1, 0, 12'h0);
    repeat (3) step();
  endtask

  function automatic int pick_pos();
    case ($urandom % 4)
      0:       return 100;
      1:       return 2040;
      2:       return 0;
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  vec_t tbl[10];

  initial begin
    int gap, vb_left, h, v;

    tbl[0] = '{100, 200, 0, 12'h0F0, 11'd0};
    tbl[1] = '{ 99, 200, 0, 12'h123, 11'd0};
    tbl[2] = '{131, 231, 0, 12'h0F0, 11'd1023};
    tbl[3] = '{132, 200, 0, 12'h123, 11'd1023};
    tbl[4] = '{115, 210, 0, 12'h0F0, 11'd335};
    tbl[5] = '{100, 199, 0, 12'h123, 11'd335};
    tbl[6] = '{100, 232, 0, 12'h123, 11'd335};
    tbl[7] = '{131, 231, 1, 12'h123, 11'd335};
    tbl[8] = '{131, 200, 0, 12'h0F0, 11'd31};
    tbl[9] = '{100, 231, 0, 12'h0F0, 11'd992};

    vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.hblnk = 0;
    vin.vsync = 0; vin.vblnk = 0; vin.rgb = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 64'(get_out()), 64'h0);
    chk("reset_addr", 64'(pixel_addr), 64'h0);
    rst_n = 1'b1;
    reset_model();
    start_game = 1'b1;

    // table vectors: player at (100,200), still, opaque ROM
    rom_mode = 0; xpos = 100; ypos = 200; moving = 0; facing_left = 0;
    fs_pulse();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].hb, 0, 12'h123);
      step();
      chk("tbl_addr", 64'(pixel_addr), 64'(tbl[i].addr));
      drive(0, 0, 1, 0, 12'h0);
      step(); step();
      chk("tbl_rgb", 64'(vout.rgb), 64'(tbl[i].rgb));
    end

    // walk animation: bit 10 toggles every AF frame starts while moving
    xpos = 300; ypos = 300; moving = 0;
    fs_pulse();
    moving = 1;
    for (int k = 1; k <= 20; k++) begin
      fs_pulse();
      drive(305, 303, 0, 0, 12'($urandom));
      step();
      chk("anim_bit", 64'(pixel_addr[10]), 64'((k / AF) % 2));
    end
    moving = 0;
    fs_pulse();
    drive(305, 303, 0, 0, 12'h456);
    step();
    chk("anim_stop", 64'(pixel_addr[10]), 64'h0);

    // facing left: left window column maps to ROM column 31 when mirrored
    facing_left = 1; xpos = 500; ypos = 40;
    fs_pulse();
    drive(500, 40, 0, 0, 12'h111); step();
    chk("mirror_left", 64'(pixel_addr[4:0]), MIRROR ? 64'd31 : 64'd0);
    drive(531, 40, 0, 0, 12'h111); step();
    chk("mirror_right", 64'(pixel_addr[4:0]), MIRROR ? 64'd0 : 64'd31);
    facing_left = 0;

    // right-edge position must not wrap
    xpos = 2040; ypos = 10;
    fs_pulse();
    drive(2047, 10, 0, 0, 12'h222); step();
    chk("edge_hit", 64'(pixel_addr), 64'd7);
    drive(2039, 10, 0, 0, 12'h222); step();
    chk("edge_left_miss", 64'(pixel_addr), 64'd7);
    drive(3, 10, 0, 0, 12'h222); step();
    chk("edge_wrap_miss", 64'(pixel_addr), 64'd7);
    drive(2040, 41, 0, 0, 12'h222); step();
    chk("edge_bottom", 64'(pixel_addr), 64'd992);

    // mid-frame position change waits for next frame start
    xpos = 100; ypos = 200;
    fs_pulse();
    xpos = 600;
    drive(100, 205, 0, 0, 12'h333); step();
    chk("old_window", 64'(pixel_addr), 64'd160);
    drive(610, 210, 0, 0, 12'h333); step();
    chk("new_not_yet", 64'(pixel_addr), 64'd160);
    fs_pulse();
    drive(610, 210, 0, 0, 12'h333); step();
    chk("new_window", 64'(pixel_addr), 64'd330);
    drive(100, 205, 0, 0, 12'h333); step();
    chk("old_gone", 64'(pixel_addr), 64'd330);

    // asynchronous reset in the middle of a line
    for (int i = 0; i < 4; i++) begin
      drive(600 + i, 205, 0, 0, 12'($urandom)); step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 64'(get_out()), 64'h0);
    chk("async_rst_addr", 64'(pixel_addr), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 6; i++) begin
      drive(10 + i, 20, 0, 0, 12'($urandom)); step();
    end

    // randomized run, one segment per ROM content
    for (int seg = 0; seg < 3; seg++) begin
      idle3();
      rom_mode = seg;
      gap = 5; vb_left = 0;
      repeat (1300) begin
        start_game = ($urandom % 12) != 0;
        if ($urandom % 30 == 0) begin
          xpos = 11'(pick_pos()); ypos = 11'(pick_pos());
          facing_left = 1'($urandom);
        end
        if (vb_left > 0) begin
          drive(int'($urandom % 2048), int'($urandom % 2048), 1'($urandom), 1, 12'($urandom));
          vb_left--;
          if (vb_left == 0) gap = int'($urandom_range(8, 30));
        end else begin
          if ($urandom % 10 == 0) begin
            h = int'($urandom % 2048); v = int'($urandom % 2048);
          end else begin
            h = (mx + int'($urandom_range(0, 40)) - 4) & 2047;
            v = (my + int'($urandom_range(0, 40)) - 4) & 2047;
          end
          drive(h, v, ($urandom % 10) == 0, 0, 12'($urandom));
          gap--;
          if (gap == 0) begin
            vb_left = int'($urandom_range(1, 3));
            xpos = 11'(pick_pos()); ypos = 11'(pick_pos());
            moving = ($urandom % 4) != 0;
            facing_left = 1'($urandom);
          end
        end
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
